pixel_writer: RTL and testbench

//  Consumer end of the line-drawing coordinate stream. Takes the (x, y) pixel pairs produced by
//  the x-counter/error-unit pair (swapped frame when steep), buffers them in a small FIFO, and
//  un-swaps steep lines. Computes the linear frame-buffer address and writes each pixel to memory

---
 rtl/pixel_writer.sv | 127 ++++++++++++
 tb/tb_pixel_writer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// pixel_writer: buffers line-drawing pixel pairs, un-swaps steep lines and writes each pixel to the
// frame buffer over req/ack. Optional clipping of off-screen pixels: define PIXEL_CLIP_EN.
module pixel_writer #(
  parameter int WIDTH   = 13,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coord_valid,
  output logic                      coord_ready,
  input  logic signed [WIDTH-1:0]   x_in,
  input  logic signed [WIDTH-1:0]   y_in,
  input  logic                      steep,
  input  logic                      last_in,
  input  logic [COLOR_W-1:0]        color_in,
  output logic                      mem_req,
  input  logic                      mem_ack,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [COLOR_W-1:0]        mem_wdata,
  output logic                      line_done,
`ifdef PIXEL_CLIP_EN
  output logic [15:0]               clip_cnt,
`endif
  output logic                      busy
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, REQ, DONE} state_t;
  state_t state, nstate;
  logic [WIDTH-1:0] fx [DEPTH];
  logic [WIDTH-1:0] fy [DEPTH];
  logic [COLOR_W-1:0] fc [DEPTH];
  logic fs [DEPTH];
  logic fl [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic alive, push, pop, empty, full, clip_hit, last_l;
  logic signed [WIDTH-1:0] px, py;
  logic [COLOR_W-1:0] col_l;
  logic signed [ADDR_W-1:0] sx, sy;
  logic [ADDR_W-1:0] lin;
  if (H_RES * V_RES > 2 ** ADDR_W) begin : g_addr_check
    $error("ADDR_W too narrow for H_RES*V_RES");
  end
  assign empty = cnt == '0;
  assign full = cnt == (PW+1)'(DEPTH);
  assign coord_ready = alive & (!full | pop);
  assign push = coord_valid & coord_ready;
  assign busy = !empty | state != IDLE;
  assign mem_req = state == REQ;
  assign line_done = state == DONE;
  // address arithmetic modulo 2^ADDR_W, so truncation happens for free
  assign sx = ADDR_W'(px);
  assign sy = ADDR_W'(py);
  assign lin = sy * ADDR_W'(H_RES) + sx;
`ifdef PIXEL_CLIP_EN
  localparam logic signed [WIDTH-1:0] XMAX = WIDTH'(H_RES);
  localparam logic signed [WIDTH-1:0] YMAX = WIDTH'(V_RES);
  assign clip_hit = px[WIDTH-1] | py[WIDTH-1] | px >= XMAX | py >= YMAX;
  always_ff @(posedge clk or negedge rst)
    if (!rst) clip_cnt <= '0;
    else if (state == ADDR && clip_hit && clip_cnt != '1) clip_cnt <= clip_cnt + 16'd1;
`else
  assign clip_hit = 1'b0;
`endif
  // a clipped pixel in ADDR takes the same exit path as an acknowledged write
  always_comb begin
    nstate = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        nstate = empty ? IDLE : ADDR;
        pop = !empty;
      end
      ADDR: begin
        nstate = clip_hit ? (last_l ? DONE : empty ? IDLE : ADDR) : REQ;
        pop = clip_hit & !last_l & !empty;
      end
      REQ: begin
        nstate = mem_ack ? (last_l ? DONE : empty ? IDLE : ADDR) : REQ;
        pop = mem_ack & !last_l & !empty;
      end
      default: begin
        nstate = empty ? IDLE : ADDR;
        pop = !empty;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      alive <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nstate;
      alive <= 1'b1;
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      if (state == ADDR && !clip_hit) begin
        mem_addr <= lin;
        mem_wdata <= col_l;
      end
    end
  always_ff @(posedge clk) begin
    if (push) begin
      fx[wp] <= x_in;
      fy[wp] <= y_in;
      fc[wp] <= color_in;
      fs[wp] <= steep;
      fl[wp] <= last_in;
    end
    if (pop) begin
      px <= fs[rp] ? fy[rp] : fx[rp];
      py <= fs[rp] ? fx[rp] : fy[rp];
      col_l <= fc[rp];
      last_l <= fl[rp];
    end
  end
endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed checks of pixel_writer addressing, handshake, back-pressure and reset.
module tb_pixel_writer;
  logic clk = 1'b0;
  logic rst, coord_valid, coord_ready, steep, last_in, mem_req, mem_ack, line_done, busy;
  logic signed [12:0] x_in, y_in;
  logic [7:0] color_in, mem_wdata;
  logic [18:0] mem_addr;
`ifdef PIXEL_CLIP_EN
  logic [15:0] clip_cnt;
`endif
  logic ack_en;
  int n_chk = 0, n_fail = 0, req_cyc = 0, done_cnt = 0, stab_err = 0, r0;
  logic [18:0] wa [$];
  logic [7:0] wd [$];
  logic prev_req = 1'b0;
  logic [18:0] prev_addr = '0;

  pixel_writer dut (
    .clk(clk), .rst(rst), .coord_valid(coord_valid), .coord_ready(coord_ready),
    .x_in(x_in), .y_in(y_in), .steep(steep), .last_in(last_in), .color_in(color_in),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .line_done(line_done),
`ifdef PIXEL_CLIP_EN
    .clip_cnt(clip_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  assign mem_ack = ack_en & mem_req;

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (mem_req) req_cyc++;
    if (line_done) done_cnt++;
    if (mem_req && prev_req && mem_addr !== prev_addr) stab_err++;
    prev_req = mem_req;
    prev_addr = mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, input int y, input int st, input int l, input int c);
    int k = 0;
    @(negedge clk);
    while (!coord_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("push_ready", coord_ready, 1);
    x_in = 13'(x);
    y_in = 13'(y);
    steep = 1'(st);
    last_in = 1'(l);
    color_in = 8'(c);
    coord_valid = 1'b1;
    tick;
    coord_valid = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < 200 && wa.size() < n; i++) @(posedge clk);
    #1;
    chk("write_count_reached", 32'(wa.size() >= n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ack_en = 1'b0;
    coord_valid = 1'b0;
    x_in = '0;
    y_in = '0;
    steep = 1'b0;
    last_in = 1'b0;
    color_in = '0;
    #3 rst = 1'b0;
    tick;
    tick;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", line_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", coord_ready, 0);
`ifdef PIXEL_CLIP_EN
    chk("rst_clip_cnt", clip_cnt, 0);
`endif
    rst = 1'b1;
    tick;
    chk("ready_after_rst", coord_ready, 1);

    // 1: single last pixel, ack in first REQ cycle
    ack_en = 1'b1;
    r0 = req_cyc;
    push(3, 2, 0, 1, 8'h5A);
    chk("t1_req_e0", mem_req, 0);
    tick;
    chk("t1_req_e1", mem_req, 0);
    chk("t1_busy", busy, 1);
    tick;
    chk("t1_req_e2", mem_req, 1);
    chk("t1_addr", mem_addr, 1283);
    chk("t1_wdata", mem_wdata, 8'h5A);
    tick;
    chk("t1_req_drop", mem_req, 0);
    chk("t1_done_pulse", line_done, 1);
    tick;
    chk("t1_done_low", line_done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_req_cycles", req_cyc - r0, 1);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: steep pixel un-swapped
    push(7, 1, 1, 1, 8'h33);
    wait_wr(2);
    tick;
    tick;
    chk("t2_addr", wa[1], 4481);
    chk("t2_wdata", wd[1], 8'h33);
    chk("t2_done_cnt", done_cnt, 2);

    // 3: stalled memory, FIFO fills (4 stored + 1 latched)
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) push(i, 1, 0, 0, 8'h10 + i);
    chk("t3_full", coord_ready, 0);
    repeat (10) tick;
    chk("t3_req_held", mem_req, 1);
    chk("t3_addr_held", mem_addr, 640);
    chk("t3_no_write", wa.size(), 2);

    // 4: push while full in the cycle the ack pops
    ack_en = 1'b1;
    x_in = 13'd5;
    y_in = 13'd1;
    steep = 1'b0;
    last_in = 1'b1;
    color_in = 8'h15;
    coord_valid = 1'b1;
    @(negedge clk);
    chk("t4_ready_on_pop", coord_ready, 1);
    tick;
    coord_valid = 1'b0;
    chk("t4_still_full", coord_ready, 0);
    wait_wr(8);
    repeat (3) tick;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t34_addr%0d", i), wa[2 + i], 640 + i);
      chk($sformatf("t34_wdata%0d", i), wd[2 + i], 8'h10 + i);
    end
    chk("t34_done_cnt", done_cnt, 3);
    chk("t34_addr_stable", stab_err, 0);
    chk("t34_idle", busy, 0);

    // 5: async reset during REQ
    ack_en = 1'b0;
    push(0, 0, 0, 1, 8'h77);
    for (int i = 0; i < 20 && !mem_req; i++) tick;
    chk("t5_req_up", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_req_drop", mem_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", line_done, 0);
    tick;
    tick;
    rst = 1'b1;
    chk("t5_ready_low", coord_ready, 0);
    tick;
    chk("t5_ready_back", coord_ready, 1);
    tick;
    chk("t5_no_done", done_cnt, 3);
    chk("t5_no_write", wa.size(), 8);

    // 6: off-screen pixels
    ack_en = 1'b1;
    push(-1, 0, 0, 0, 8'h01);
    push(640, 5, 0, 0, 8'h02);
    push(10, 10, 0, 1, 8'h03);
`ifdef PIXEL_CLIP_EN
    wait_wr(9);
    repeat (4) tick;
    chk("t6_write_cnt", wa.size(), 9);
    chk("t6_addr", wa[8], 6410);
    chk("t6_wdata", wd[8], 8'h03);
    chk("t6_clip_cnt", clip_cnt, 2);
`else
    wait_wr(11);
    repeat (4) tick;
    chk("t6_write_cnt", wa.size(), 11);
    chk("t6_addr_neg", wa[8], 19'h7FFFF);
    chk("t6_addr_wide", wa[9], 3840);
    chk("t6_addr", wa[10], 6410);
`endif
    chk("t6_done_cnt", done_cnt, 4);
    chk("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
